bus_cycle_gen: RTL and testbench
================================

BUS_CYCLE_GEN -- requirements
Module: bus_cycle_gen

Interface
REQ-001 Parameter MAX_WAIT, default 16; maximum consecutive wait states before a cycle is aborted.
REQ-002 CLK  input  1  system clock; all state changes on posedge CLK.
REQ-003 RESET  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-004 req  input  1  request a bus cycle; sampled only when busy=0.
REQ-005 req_wr  input  1  1=write, 0=read.
REQ-006 req_io  input  1  1=I/O space, 0=memory space.
REQ-007 req_addr  input  20  cycle address.
REQ-008 req_wdata  input  8  write data.
REQ-009 busy  output  1  high from T1 through T4 inclusive.
REQ-010 done  output  1  one-cycle pulse in T4.
REQ-011 err  output  1  valid with done; 1=wait-state timeout.
REQ-012 rdata  output  8  read data; valid with done, held until the next done.
REQ-013 AD  inout  8  multiplexed address/data bus; high-Z when not driven.
REQ-014 A  output  12  address bits 19:8.
REQ-015 ALE  output  1  address latch enable, active high.
REQ-016 IOM  output  1  1=I/O cycle, 0=memory cycle.
REQ-017 RD, WR  output  1 each  read/write strobes, active low.
REQ-018 DTR  output  1  1=transmit (write), 0=receive (read).
REQ-019 DEN  output  1  transceiver enable, active low.
REQ-020 READY  input  1  responder ready; 0 inserts wait states.

Function
REQ-021 States IDLE, T1, T2, T3, TW, T4; all outputs registered.
REQ-022 IDLE: req=1 at a posedge captures req_* into internal registers and enters T1; later req_* changes are ignored until the next acceptance.
REQ-023 T1: ALE=1, AD=addr[7:0], A=addr[19:8], IOM=req_io, DTR=req_wr, RD=WR=DEN=1.
REQ-024 T2 always goes to T3. In T2 and T3: ALE=0, A held, DEN=0. Write: AD=wdata, WR=0. Read: AD high-Z, RD=0.
REQ-025 At the posedge ending T3 or TW: READY=1 enters T4; READY=0 enters (or stays in) TW, which keeps the T2/T3 outputs.
REQ-026 Read data: AD is captured into rdata at the posedge that leaves T3/TW with READY=1.
REQ-027 The wait counter clears in T1. When MAX_WAIT consecutive TW cycles elapse with READY=0, the next edge enters T4 with err=1; on a read, rdata=8'hFF.
REQ-028 T4: RD=WR=DEN=1; write data still driven on AD; read AD high-Z; done=1.
REQ-029 Leaving T4: req=1 enters T1 directly, capturing new req_* (back-to-back); otherwise enters IDLE.
REQ-030 Latency with no waits: req sampled at edge k gives T1 in cycle k+1 and done in cycle k+4. Each wait state adds one cycle.
REQ-031 AD is driven only in T1, and in T2/T3/TW/T4 of a write; it is never driven during a read data phase.
REQ-032 IDLE outputs: ALE=0, RD=WR=DEN=1, DTR=1, AD high-Z, A=0, IOM holds its last value, busy=0.

Reset
REQ-033 RESET=1 at a posedge enters IDLE from any state, including mid-cycle; the aborted cycle produces no done.
REQ-034 Reset values: ALE=0, RD=WR=DEN=1, DTR=1, IOM=0, A=0, AD high-Z, busy=0, done=0, err=0, rdata=0, wait counter=0.

Structure
REQ-035 Shared package bus_pkg holds the state enum, the MAX_WAIT default, and the idle/reset strobe constants.
REQ-036 Single module; no sub-module. AD tri-state is driven by one continuous assignment from a registered output-enable.

Verification
REQ-037 Memory read: addr 20'h00010, READY=1, responder returns 8'h5A. Expect ALE high 1 cycle, IOM=0, RD low for 2 cycles, done at k+4, rdata=8'h5A, err=0.
REQ-038 I/O write: addr 20'h0FF00, data 8'hC3, READY low for 2 sampled edges. Expect IOM=1, DTR=1, WR low for 4 cycles, AD=8'hC3 from T2 to T4, done at k+6.
REQ-039 Back-to-back: req held high for a write then a read. Expect T4 followed directly by T1 with no IDLE cycle; two done pulses 4 cycles apart.
REQ-040 Timeout: READY stuck 0 on a read. Expect exactly 16 TW cycles, then done with err=1, rdata=8'hFF, and return to IDLE.
REQ-041 Reset in TW of a write. Expect IDLE on the next edge, WR=1, DEN=1, AD high-Z, no done pulse.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding, wait-state default and idle strobe levels for bus_cycle_gen
package bus_pkg;
  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4} state_t;
  typedef struct packed {
    logic ale;
    logic rd_n;
    logic wr_n;
    logic den_n;
    logic dtr;
  } strb_t;
  localparam int MAX_WAIT_DEF = 16;
  localparam strb_t STRB_IDLE = '{ale: 1'b0, rd_n: 1'b1, wr_n: 1'b1, den_n: 1'b1, dtr: 1'b1};
endpackage

// File: rtl/bus_cycle_gen.sv
// bus_cycle_gen: T1/T2/T3/TW/T4 multiplexed-bus cycle generator with wait-state timeout
module bus_cycle_gen
  import bus_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic        req_wr,
  input  logic        req_io,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  inout  wire  [7:0]  AD,
  output logic [11:0] A,
  output logic        ALE,
  output logic        IOM,
  output logic        RD,
  output logic        WR,
  output logic        DTR,
  output logic        DEN,
  input  logic        READY
);
  localparam int WW = $clog2(MAX_WAIT + 1);
  state_t r_state, w_nxt;
  strb_t r_strb, w_strb;
  logic r_wr, r_io, r_oe;
  logic [19:0] r_addr;
  logic [7:0] r_wdata, r_ad;
  logic [WW-1:0] r_wait;
  logic w_acc, w_to, w_wr, w_io, w_data_ph;
  logic [19:0] w_addr;
  logic [7:0] w_wdata;
  assign AD = r_oe ? r_ad : 'z;
  assign {ALE, RD, WR, DEN, DTR} = r_strb;
  assign w_acc = req && (r_state == S_IDLE || r_state == S_T4);
  assign w_to = r_state == S_TW && !READY && r_wait == WW'(MAX_WAIT - 1);
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else r_state <= w_nxt;
  end
  always_comb begin
    w_nxt = S_IDLE;
    case (r_state)
      S_IDLE:     w_nxt = req ? S_T1 : S_IDLE;
      S_T1:       w_nxt = S_T2;
      S_T2:       w_nxt = S_T3;
      S_T3, S_TW: w_nxt = (READY || w_to) ? S_T4 : S_TW;
      S_T4:       w_nxt = req ? S_T1 : S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
  end
  // outputs are computed for the state being entered so they register in step with it
  always_comb begin
    w_wr = w_acc ? req_wr : r_wr;
    w_io = w_acc ? req_io : r_io;
    w_addr = w_acc ? req_addr : r_addr;
    w_wdata = w_acc ? req_wdata : r_wdata;
    w_data_ph = w_nxt == S_T2 || w_nxt == S_T3 || w_nxt == S_TW;
    w_strb = STRB_IDLE;
    w_strb.ale = w_nxt == S_T1;
    w_strb.rd_n = !(w_data_ph && !w_wr);
    w_strb.wr_n = !(w_data_ph && w_wr);
    w_strb.den_n = !w_data_ph;
    w_strb.dtr = w_nxt == S_IDLE ? 1'b1 : w_wr;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_strb <= STRB_IDLE;
      {r_wr, r_io, r_addr, r_wdata} <= '0;
      r_wait <= '0;
      r_oe <= 1'b0;
      r_ad <= '0;
      A <= '0;
      IOM <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      rdata <= '0;
    end else begin
      r_strb <= w_strb;
      if (w_acc) {r_wr, r_io, r_addr, r_wdata} <= {req_wr, req_io, req_addr, req_wdata};
      r_wait <= r_state == S_T1 ? '0 : (r_state == S_TW && !READY) ? r_wait + WW'(1) : r_wait;
      r_oe <= w_nxt == S_T1 || (w_wr && (w_data_ph || w_nxt == S_T4));
      r_ad <= w_nxt == S_T1 ? w_addr[7:0] : w_wdata;
      A <= w_nxt == S_IDLE ? '0 : w_addr[19:8];
      IOM <= w_nxt == S_IDLE ? IOM : w_io;
      busy <= w_nxt != S_IDLE;
      done <= w_nxt == S_T4;
      err <= w_nxt == S_T4 && w_to;
      if (w_nxt == S_T4 && !r_wr) rdata <= w_to ? 8'hFF : AD;
    end
  end
endmodule

// File: tb/tb_bus_cycle_gen.sv
// tb_bus_cycle_gen: scoreboard bench for bus_cycle_gen (reads, writes, waits, back-to-back, timeout, reset abort)
module tb_bus_cycle_gen;
  localparam int MW = 16;
  typedef struct {
    logic wr;
    logic io;
    logic [19:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic err;
    int lat;
    int lo;
    int t0;
  } exp_t;
  logic CLK = 0, RESET = 1, req = 0, req_wr = 0, req_io = 0, READY = 1;
  logic [19:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic busy, done, err, ALE, IOM, RD, WR, DTR, DEN;
  logic [7:0] rdata;
  logic [11:0] A;
  wire [7:0] AD;
  logic tb_oe = 0, probe = 0;
  logic [7:0] tb_d = 0, probe_d = 0, resp_data = 0;
  int n_wait = 0, cyc = 0, n_chk = 0, n_fail = 0, last_done = 0, prev_done = 0;
  exp_t sb[$];
  assign AD = tb_oe ? tb_d : 8'hzz;
  bus_cycle_gen dut (
    .CLK(CLK), .RESET(RESET), .req(req), .req_wr(req_wr), .req_io(req_io),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .AD(AD), .A(A), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR),
    .DTR(DTR), .DEN(DEN), .READY(READY)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(negedge CLK);
    #1;
  endtask
  task automatic issue(logic wr, logic io, logic [19:0] addr, logic [7:0] wd, logic [7:0] rd,
                       int waits, int dly, int hold);
    exp_t e;
    int w;
    w = waits > MW ? MW : waits;
    e.wr = wr;
    e.io = io;
    e.addr = addr;
    e.wdata = wd;
    e.err = waits > MW;
    e.rdata = e.err ? 8'hFF : rd;
    e.lat = 4 + w;
    e.lo = 2 + w;
    e.t0 = cyc + dly;
    sb.push_back(e);
    req = 1;
    req_wr = wr;
    req_io = io;
    req_addr = addr;
    req_wdata = wd;
    n_wait = waits;
    if (!wr) resp_data = rd;
    if (hold > 0) begin
      repeat (hold) step();
      req = 0;
      req_addr = 20'($urandom);
      req_wdata = 8'($urandom);
      req_wr = 1'($urandom);
      req_io = 1'($urandom);
    end
  endtask
  task automatic wait_done(string tag, int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      step();
      n++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask
  task automatic probe_hiz(string tag);
    probe_d = 8'($urandom);
    probe = 1;
    step();
    check(tag, 32'(AD), 32'(probe_d));
    probe = 0;
    step();
  endtask
  // responder: drives read data while RD is low, raises READY after the requested waits
  initial begin
    int s;
    s = 0;
    forever begin
      @(negedge CLK);
      s = (!RD || !WR) ? s + 1 : 0;
      READY = s >= 2 + n_wait;
      tb_oe = !RD || probe;
      tb_d = probe ? probe_d : resp_data;
    end
  end
  initial begin
    int ale_n, lo_n, ad_bad;
    exp_t e;
    ale_n = 0;
    lo_n = 0;
    ad_bad = 0;
    forever begin
      @(negedge CLK);
      if (!busy) begin
        ale_n = 0;
        lo_n = 0;
        ad_bad = 0;
      end else begin
        if (ALE) begin
          ale_n++;
          if (sb.size() > 0) check("t1_iom_dtr_a_ad", 32'({IOM, DTR, A, AD}), 32'({sb[0].io, sb[0].wr, sb[0].addr}));
        end
        if (!RD || !WR) lo_n++;
        if (sb.size() > 0 && sb[0].wr && (!WR || done) && AD !== sb[0].wdata) ad_bad++;
        if (done) begin
          if (sb.size() == 0) check("spurious_done", 32'(done), 32'd0);
          else begin
            e = sb.pop_front();
            check("ale_cycles", 32'(ale_n), 32'(1));
            check("strobe_low_cycles", 32'(lo_n), 32'(e.lo));
            check("done_latency", 32'(cyc - e.t0), 32'(e.lat));
            check("err", 32'(err), 32'(e.err));
            check("t4_strobes", 32'({RD, WR, DEN}), 32'(3'b111));
            if (e.wr) check("write_ad", 32'(ad_bad), 32'd0);
            else check("rdata", 32'(rdata), 32'(e.rdata));
          end
          prev_done = last_done;
          last_done = cyc;
          ale_n = 0;
          lo_n = 0;
          ad_bad = 0;
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) step();
    check("reset_values", 32'({ALE, RD, WR, DEN, DTR, IOM, A, busy, done, err, rdata}),
          32'({1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 8'h00}));
    probe_hiz("ad_hiz_reset");
    RESET = 0;
    step();
    issue(1'b0, 1'b0, 20'h00010, 8'h00, 8'h5A, 0, 0, 1);
    wait_done("mem_read_drain", 30);
    step();
    check("idle_after_read", 32'({ALE, RD, WR, DEN, DTR, IOM, A, busy}), 32'({5'b01111, 1'b0, 12'h000, 1'b0}));
    issue(1'b1, 1'b1, 20'h0FF00, 8'hC3, 8'h00, 2, 0, 1);
    wait_done("io_write_drain", 30);
    step();
    check("idle_iom_hold", 32'({IOM, busy, DTR}), 32'(3'b101));
    probe_hiz("ad_hiz_idle");
    issue(1'b1, 1'b0, 20'h12345, 8'h77, 8'h00, 0, 0, 0);
    step();
    issue(1'b0, 1'b1, 20'h54321, 8'h00, 8'h3C, 0, 3, 4);
    wait_done("b2b_drain", 30);
    check("b2b_done_gap", 32'(last_done - prev_done), 32'd4);
    issue(1'b0, 1'b0, 20'h00AAA, 8'h00, 8'hE7, 16, 0, 1);
    wait_done("max_wait_read_drain", 40);
    issue(1'b0, 1'b0, 20'hA0A0A, 8'h00, 8'h11, 100, 0, 1);
    wait_done("timeout_drain", 40);
    step();
    check("timeout_to_idle", 32'({busy, done, err}), 32'd0);
    issue(1'b1, 1'b0, 20'hFFFFF, 8'h0F, 8'h00, 0, 0, 1);
    wait_done("write_drain", 30);
    issue(1'b1, 1'b0, 20'h33333, 8'h99, 8'h00, 100, 0, 1);
    for (int i = 0; i < 20 && WR; i++) step();
    check("abort_wr_low", 32'(WR), 32'd0);
    repeat (3) step();
    RESET = 1;
    step();
    check("abort_idle", 32'({busy, done, WR, DEN, ALE}), 32'(5'b00110));
    RESET = 0;
    sb.delete();
    probe_hiz("ad_hiz_abort");
    repeat (4) step();
    issue(1'b0, 1'b0, 20'h00FFF, 8'h00, 8'h81, 1, 0, 1);
    wait_done("recover_read_drain", 30);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
